// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the audio level detector.
package audio_pkg;
  localparam int AUDIO_W = 32;
  localparam int MAG_W   = 31;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_POP  = 2'd1,
    ST_EVAL = 2'd2
  } state_t;
endpackage

// File: rtl/audio_abs_sat.sv
// Saturating magnitude of a signed sample; the most negative value clamps to full scale.
module audio_abs_sat
  import audio_pkg::*;
(
  input  logic [AUDIO_W-1:0] i_sample,
  output logic [MAG_W-1:0]   o_mag
);

  logic [AUDIO_W-1:0] w_neg;

  assign w_neg = ~i_sample + 32'd1;

  always_comb begin
    o_mag = i_sample[MAG_W-1:0];
    if (i_sample[AUDIO_W-1] == 1'b0) begin
      o_mag = i_sample[MAG_W-1:0];
    end else if (i_sample == 32'h8000_0000) begin
      o_mag = 31'h7FFF_FFFF;
    end else begin
      o_mag = w_neg[MAG_W-1:0];
    end
  end

endmodule

// File: rtl/audio_level_detect.sv
// Windowed peak detector with hit counting and release hysteresis on an Audio_Controller FIFO.
// Define AUDIO_DETECT_STEREO_EN to take the louder of both channels; otherwise only left is used.
module audio_level_detect
  import audio_pkg::*;
#(
  parameter int          WINDOW_SAMPLES = 480,
  parameter logic [31:0] THRESHOLD      = 32'd10000000,
  parameter logic [31:0] RELEASE        = 32'd5000000,
  parameter int          HIT_WINDOWS    = 3
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      audio_in_available,
  input  logic signed [AUDIO_W-1:0] left_channel_audio_in,
  input  logic signed [AUDIO_W-1:0] right_channel_audio_in,
  output logic                      read_audio_in,
  output logic                      detect,
  output logic                      armed,
  output logic [MAG_W-1:0]          peak_level
);

  localparam logic [15:0] L_WIN = WINDOW_SAMPLES[15:0];
  localparam logic [3:0]  L_HIT = HIT_WINDOWS[3:0];

  state_t           r_state;
  logic             r_read;
  logic             r_detect;
  logic             r_armed;
  logic             r_pop_en;
  logic [MAG_W-1:0] r_level;
  logic [MAG_W-1:0] r_mag;
  logic [MAG_W-1:0] r_peak;
  logic [15:0]      r_cnt;
  logic [3:0]       r_hit;

  logic [MAG_W-1:0] w_mag;
  logic [MAG_W-1:0] w_mag_l;
  logic [MAG_W-1:0] w_new_peak;
  logic [15:0]      w_cnt_inc;
  logic             w_win_end;
  logic             w_loud;
  logic             w_quiet;
  logic [3:0]       w_hit_next;

  audio_abs_sat u_abs_l (.i_sample(left_channel_audio_in), .o_mag(w_mag_l));

`ifdef AUDIO_DETECT_STEREO_EN
  logic [MAG_W-1:0] w_mag_r;
  audio_abs_sat u_abs_r (.i_sample(right_channel_audio_in), .o_mag(w_mag_r));
  assign w_mag = (w_mag_l >= w_mag_r) ? w_mag_l : w_mag_r;
`else
  logic w_unused_right;
  assign w_unused_right = ^right_channel_audio_in;
  assign w_mag = w_mag_l;
`endif

  always_comb begin
    w_new_peak = (r_mag > r_peak) ? r_mag : r_peak;
    w_cnt_inc  = r_cnt + 16'd1;
    w_win_end  = (w_cnt_inc == L_WIN);
    w_loud     = ({1'b0, w_new_peak} >= THRESHOLD);
    w_quiet    = ({1'b0, w_new_peak} < RELEASE);
    w_hit_next = 4'd0;
    if (!w_loud) begin
      w_hit_next = 4'd0;
    end else if (r_hit >= L_HIT) begin
      w_hit_next = L_HIT;
    end else begin
      w_hit_next = r_hit + 4'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= ST_WAIT;
      r_read   <= 1'b0;
      r_detect <= 1'b0;
      r_armed  <= 1'b1;
      r_pop_en <= 1'b0;
      r_level  <= 31'd0;
      r_mag    <= 31'd0;
      r_peak   <= 31'd0;
      r_cnt    <= 16'd0;
      r_hit    <= 4'd0;
    end else begin
      r_read   <= 1'b0;
      r_detect <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (audio_in_available) begin
            r_state <= ST_POP;
            r_read  <= 1'b1;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_POP: begin
          // Sample pair is captured in the same cycle the pop strobe is high.
          r_mag    <= w_mag;
          r_pop_en <= enable;
          r_state  <= ST_EVAL;
        end
        ST_EVAL: begin
          r_state <= ST_WAIT;
          if (enable && r_pop_en) begin
            if (w_win_end) begin
              r_level <= w_new_peak;
              r_peak  <= 31'd0;
              r_cnt   <= 16'd0;
              r_hit   <= w_hit_next;
              if (r_armed && (w_hit_next == L_HIT)) begin
                r_detect <= 1'b1;
                r_armed  <= 1'b0;
              end else if (w_quiet) begin
                r_armed <= 1'b1;
              end else begin
                r_armed <= r_armed;
              end
            end else begin
              r_peak <= w_new_peak;
              r_cnt  <= w_cnt_inc;
            end
          end else begin
            r_peak <= 31'd0;
            r_cnt  <= 16'd0;
          end
        end
        default: r_state <= ST_WAIT;
      endcase
      // Disabled: window state stays cleared so re-enabling starts a fresh window.
      if (!enable) begin
        r_peak <= 31'd0;
        r_cnt  <= 16'd0;
        r_hit  <= 4'd0;
      end
    end
  end

  assign read_audio_in = r_read;
  assign detect        = r_detect;
  assign armed         = r_armed;
  assign peak_level    = r_level;

endmodule

// File: tb/tb_audio_level_detect.sv
// Directed plus randomized bench for audio_level_detect against a window-list reference model.
module tb_audio_level_detect;
  localparam int     WIN = 4;
  localparam int     HIT = 2;
  localparam longint THR = 64'd10000000;
  localparam longint REL = 64'd5000000;

  logic               CLOCK_50 = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b1;
  logic               audio_in_available = 1'b0;
  logic signed [31:0] left_channel_audio_in = 32'sd0;
  logic signed [31:0] right_channel_audio_in = 32'sd0;
  logic               read_audio_in;
  logic               detect;
  logic               armed;
  logic [30:0]        peak_level;

  int checks = 0;
  int failures = 0;

  longint win_q[$];
  int     run_len = 0;
  bit     m_armed = 1'b1;
  longint m_level = 0;

  audio_level_detect #(
    .WINDOW_SAMPLES(WIN), .THRESHOLD(32'd10000000), .RELEASE(32'd5000000), .HIT_WINDOWS(HIT)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
    .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_channel_audio_in),
    .right_channel_audio_in(right_channel_audio_in),
    .read_audio_in(read_audio_in), .detect(detect), .armed(armed), .peak_level(peak_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint mag_of(input logic signed [31:0] s);
    longint v;
    v = longint'(s);
    if (v < 0) v = -v;
    if (v > 64'd2147483647) v = 64'd2147483647;
    return v;
  endfunction

  // Reference: collect WIN magnitudes, judge each finished window by its maximum.
  task automatic model_sample(input longint mag, input bit en, output bit exp_det);
    longint pk;
    exp_det = 1'b0;
    if (!en) begin
      win_q.delete();
      run_len = 0;
      return;
    end
    win_q.push_back(mag);
    if (win_q.size() == WIN) begin
      pk = 0;
      foreach (win_q[k]) if (win_q[k] > pk) pk = win_q[k];
      win_q.delete();
      m_level = pk;
      if (pk >= THR) run_len++; else run_len = 0;
      if (m_armed && run_len >= HIT) begin
        exp_det = 1'b1;
        m_armed = 1'b0;
      end else if (pk < REL) begin
        m_armed = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    run_len = 0;
    m_armed = 1'b1;
    m_level = 0;
  endtask

  // Offer one sample pair, wait for its pop and evaluation, then compare outputs.
  task automatic push_sample(input logic signed [31:0] l, input logic signed [31:0] r);
    bit     got;
    bit     e_det;
    longint m;
    left_channel_audio_in  = l;
    right_channel_audio_in = r;
    audio_in_available     = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge CLOCK_50);
      if (read_audio_in === 1'b1) got = 1'b1;
    end
    check("pop_seen", longint'(got), 64'd1);
    audio_in_available = 1'b0;
`ifdef AUDIO_DETECT_STEREO_EN
    m = (mag_of(l) > mag_of(r)) ? mag_of(l) : mag_of(r);
`else
    m = mag_of(l);
`endif
    model_sample(m, enable, e_det);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("detect", longint'(detect), longint'(e_det));
    check("armed", longint'(armed), longint'(m_armed));
    check("peak_level", longint'(peak_level), m_level);
    @(negedge CLOCK_50);
    check("detect_one_cycle", longint'(detect), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    check("rst_read", longint'(read_audio_in), 64'd0);
    check("rst_detect", longint'(detect), 64'd0);
    check("rst_armed", longint'(armed), 64'd1);
    check("rst_level", longint'(peak_level), 64'd0);
    model_reset();
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  initial begin
    int          pops;
    int          last_pop;
    int          min_gap;
    logic [30:0] held_level;
    logic signed [31:0] v;
    int          cat;

    // Reset state
    pulse_reset();

    // Two loud windows fire once after the 8th sample
    for (int i = 0; i < 8; i++) push_sample(32'sd20000000, 32'sd0);
    check("req030_armed", longint'(armed), 64'd0);
    check("req030_level", longint'(peak_level), 64'd20000000);

    // Mid window keeps armed low, quiet window re-arms
    for (int i = 0; i < 4; i++) push_sample(32'sd7000000, 32'sd0);
    check("req031_armed_mid", longint'(armed), 64'd0);
    for (int i = 0; i < 4; i++) push_sample(32'sd1000, -32'sd30000000);
    check("req031_armed_quiet", longint'(armed), 64'd1);

    // Most negative sample saturates
    v = 32'sh8000_0000;
    push_sample(v, 32'sd0);
    for (int i = 0; i < 3; i++) push_sample(32'sd5, 32'sd0);
    check("req032_sat", longint'(peak_level), 64'd2147483647);

    // Continuous availability while disabled: pop spacing and count
    enable = 1'b0;
    held_level = peak_level;
    left_channel_audio_in = 32'sd20000000;
    audio_in_available = 1'b1;
    pops = 0;
    last_pop = -100;
    min_gap = 100;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (read_audio_in === 1'b1) begin
        pops++;
        if (i - last_pop < min_gap) min_gap = i - last_pop;
        last_pop = i;
      end
      check("req033_no_detect", longint'(detect), 64'd0);
    end
    audio_in_available = 1'b0;
    model_reset_window_only();
    check("req033_pops", longint'(pops), 64'd7);
    check("req033_min_gap", longint'(min_gap), 64'd3);
    repeat (3) @(negedge CLOCK_50);

    // Disabled loud samples are drained and ignored
    for (int i = 0; i < 8; i++) push_sample(32'sd20000000, 32'sd0);
    check("req034_level_held", longint'(peak_level), longint'(held_level));
    enable = 1'b1;

    // Reset mid-window discards partial progress
    for (int i = 0; i < 4; i++) push_sample(32'sd15000000, 32'sd0);
    for (int i = 0; i < 3; i++) push_sample(32'sd15000000, 32'sd0);
    pulse_reset();
    for (int i = 0; i < 4; i++) push_sample(32'sd15000000, 32'sd0);
    check("req035_no_early", longint'(armed), 64'd1);
    for (int i = 0; i < 4; i++) push_sample(32'sd15000000, 32'sd0);
    check("req035_fired", longint'(armed), 64'd0);

    // Randomized samples, boundary magnitudes and enable toggles
    for (int i = 0; i < 60; i++) begin
      cat = int'($urandom_range(0, 5));
      case (cat)
        0: v = 32'($urandom_range(10000000, 40000000));
        1: v = 32'($urandom_range(5000000, 9999999));
        2: v = 32'($urandom_range(0, 4999999));
        3: v = 32'sd10000000;
        4: v = 32'sd5000000;
        default: v = 32'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      push_sample(v, 32'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic model_reset_window_only();
    win_q.delete();
    run_len = 0;
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
